// File: rtl/paint_cursor_ctrl_pkg.sv
// Shared definitions for the paint pipeline: cursor geometry, step FSM encodings, VRAM address formation.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package paint_cursor_ctrl_pkg;

  localparam int SCREEN_DIM = 256;
  localparam int COORD_W    = $clog2(SCREEN_DIM);
  localparam int ADDR_W     = 2 * COORD_W;

  // Cursor starts mid-screen on both axes.
  localparam logic [COORD_W-1:0] CURSOR_RST = COORD_W'(128);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } step_state_e;

  // Row-major VRAM address; the colour stage forms its read address the same way.
  function automatic logic [ADDR_W-1:0] vram_addr(input logic [COORD_W-1:0] y,
                                                  input logic [COORD_W-1:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/paint_cursor_ctrl_btn_step.sv
// Conditions one raw button: 2-flop sync, debounce, step FSM with hold/auto-repeat.
// Latency: raw edge -> debounced level 2 + DB_CYCLES cycles; step is combinational from level/state.
// Backpressure: none; step pulses are single-cycle and must be consumed when asserted.
// Ports: clk, rst (async, active-high), raw_i (asynchronous button),
//        lvl_o (debounced level), step_o (one-cycle step pulse).
module btn_step
  import paint_cursor_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic step_o
);

  localparam int DB_W    = $clog2(DB_CYCLES + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic              sync1_q, sync2_q;
  logic              lvl_q, lvl_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  step_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold_done, rep_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The count only runs while the synchronized input disagrees with the
  // accepted level; any cycle of agreement (a bounce) restarts it.
  always_comb begin
    lvl_d    = lvl_q;
    db_cnt_d = '0;
    if (sync2_q != lvl_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        lvl_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q    <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      lvl_q    <= lvl_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign hold_done = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign rep_done  = (cnt_q == CNT_W'(REPEAT_CYCLES - 1));

  // Step FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step FSM: next state. IDLE is only ever re-entered with the level low,
  // so a high level seen in IDLE is exactly the debounced rising edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (lvl_q) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (!lvl_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (hold_done) begin
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!lvl_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (rep_done) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Step FSM: outputs. A release wins over a coinciding timer expiry.
  always_comb begin
    step_o = 1'b0;
    case (state_q)
      ST_IDLE:   step_o = lvl_q;
      ST_DELAY:  step_o = lvl_q && hold_done;
      ST_REPEAT: step_o = lvl_q && rep_done;
      default:   step_o = 1'b0;
    endcase
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/paint_cursor_ctrl.sv
// Paint cursor control: conditions buttons/draw switch, moves the (x,y) cursor, issues VRAM write strobes.
// Latency: step -> x/y next edge; x/y change (pen down) or pen rise -> we one cycle later.
// Backpressure: none; the VRAM write port accepts a write every cycle.
// Ports: clk, rst (async, active-high); btn_up/down/left/right, draw (raw async); color (pen colour);
//        x, y (cursor); we, waddr ({y,x}), wdata (colour latched on the trigger edge).
module paint_cursor_ctrl
  import paint_cursor_ctrl_pkg::*;
#(
  parameter int DB_CYCLES     = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        draw,
  input  logic [11:0] color,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        we,
  output logic [15:0] waddr,
  output logic [11:0] wdata
);

  // Bit order: [3]=up, [2]=down, [1]=left, [0]=right.
  logic [3:0] dir_raw, dir_step, dir_lvl_unused;
  logic       pen, draw_step_unused;

  assign dir_raw = {btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 4; i++) begin : g_dir
    btn_step #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw_i (dir_raw[i]),
      .lvl_o (dir_lvl_unused[i]),
      .step_o(dir_step[i])
    );
  end

  // The draw switch shares the conditioning path; only its level is consumed.
  btn_step #(
    .DB_CYCLES    (DB_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_draw (
    .clk   (clk),
    .rst   (rst),
    .raw_i (draw),
    .lvl_o (pen),
    .step_o(draw_step_unused)
  );

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               moved_q, moved_d;
  logic               pen_q;
  logic               trigger;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [11:0]        wdata_q, wdata_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    // Opposing steps in the same cycle cancel; coordinates wrap modulo 256.
    if (dir_step[0] && !dir_step[1])      x_d = x_q + COORD_W'(1);
    else if (dir_step[1] && !dir_step[0]) x_d = x_q - COORD_W'(1);
    if (dir_step[2] && !dir_step[3])      y_d = y_q + COORD_W'(1);
    else if (dir_step[3] && !dir_step[2]) y_d = y_q - COORD_W'(1);
    // Only a net change of position counts as a move.
    moved_d = (x_d != x_q) || (y_d != y_q);

    // moved_q marks the cycle in which x_q/y_q show the new position, which
    // puts the write strobe one cycle after the coordinate change.
    trigger = pen && (moved_q || !pen_q);
    we_d    = trigger;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (trigger) begin
      waddr_d = vram_addr(y_q, x_q);
      wdata_d = color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= CURSOR_RST;
      y_q     <= CURSOR_RST;
      moved_q <= 1'b0;
      pen_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= vram_addr(CURSOR_RST, CURSOR_RST);
      wdata_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      moved_q <= moved_d;
      pen_q   <= pen;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Bench for paint_cursor_ctrl with short debounce/hold/repeat timings.
// Cursor position is modelled per cycle; expected VRAM writes are queued with their due cycle.
// Every cycle the monitor either retires the due write or requires we=0.
module tb_paint_cursor_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  // Press (driven just after an edge) to coordinate change: 2 sync + DB + 1 edges.
  localparam int LAT  = 2 + DB + 1;

  logic        clk;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right, draw;
  logic [11:0] color;
  logic [7:0]  x, y;
  logic        we;
  logic [15:0] waddr;
  logic [11:0] wdata;

  paint_cursor_ctrl #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .draw     (draw),
    .color    (color),
    .x        (x),
    .y        (y),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [11:0] data;
  } wr_t;

  wr_t        sb[$];
  wr_t        cur;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         mon_en   = 0;
  bit         pen      = 0;
  logic [7:0] mx, my;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: at the due cycle the head entry must appear, otherwise we must be low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        cur = sb.pop_front();
        check("we", 32'(we), 32'd1);
        check("waddr", 32'(waddr), 32'(cur.addr));
        check("wdata", 32'(wdata), 32'(cur.data));
      end else begin
        check("we_idle", 32'(we), 32'd0);
      end
    end
  end

  // Steps that have reached x/y by edge i of a press held for r cycles.
  function automatic int steps_by(input int i, input int r);
    int n   = 0;
    int lim = (i < r + 2 + DB) ? i : r + 2 + DB;
    if (r < DB) return 0;
    for (int c = LAT; c <= lim; c += (c == LAT) ? HOLD : REP) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask = {up, down, left, right}; held for r cycles, then settled, checking x/y every cycle.
  task automatic press_hold(input logic [3:0] mask, input int r);
    int base, prev, n, dx, dy;
    dx = int'(mask[0]) - int'(mask[1]);
    dy = int'(mask[2]) - int'(mask[3]);
    {btn_up, btn_down, btn_left, btn_right} = mask;
    base = cyc;
    prev = 0;
    for (int i = 1; i <= r + 12; i++) begin
      tick();
      if (i == r) {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
      n = steps_by(i, r);
      if (n != prev) begin
        mx = mx + 8'(dx);
        my = my + 8'(dy);
        if (pen && (dx != 0 || dy != 0))
          sb.push_back('{cyc: base + i + 1, addr: {my, mx}, data: color});
        prev = n;
      end
      check("x", 32'(x), 32'(mx));
      check("y", 32'(y), 32'(my));
    end
  endtask

  task automatic set_draw(input logic v);
    int base;
    base = cyc;
    draw = v;
    if (v && !pen) sb.push_back('{cyc: base + LAT, addr: {my, mx}, data: color});
    repeat (12) tick();
    pen = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b1;
    sb.delete();
    mx = 8'd128;
    my = 8'd128;
    pen = 1'b0;
    #1;
    check("rst_x", 32'(x), 32'd128);
    check("rst_y", 32'(y), 32'd128);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'h8080);
    check("rst_wdata", 32'(wdata), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, draw} = 5'b0;
    color = 12'h000;
    tick();
    do_reset();

    // Idle: nothing moves, no writes.
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_x", 32'(x), 32'd128);
      check("idle_y", 32'(y), 32'd128);
      check("idle_waddr", 32'(waddr), 32'h8080);
    end

    // Too short to debounce, then one clean single step.
    press_hold(4'b0001, 3);
    press_hold(4'b0001, 10);
    check("single_right_x", 32'(x), 32'd129);

    // Hold up: steps at t0, t0+HOLD, then every REP; release lands after the 5th step.
    press_hold(4'b1000, 38);
    check("repeat_up_y", 32'(y), 32'd123);

    // Drive to the (255,0) corner, then wrap both axes in one cycle.
    press_hold(4'b0001, 643);
    press_hold(4'b1000, 628);
    check("corner_x", 32'(x), 32'd255);
    check("corner_y", 32'(y), 32'd0);
    press_hold(4'b1001, 10);
    check("wrap_x", 32'(x), 32'd0);
    check("wrap_y", 32'(y), 32'd255);

    // Drawing from the reset position.
    tick();
    do_reset();
    color = 12'hF00;
    set_draw(1'b1);
    press_hold(4'b0010, 10);
    check("draw_left_x", 32'(x), 32'd127);
    press_hold(4'b1100, 10);
    check("cancel_y", 32'(y), 32'd128);
    set_draw(1'b0);

    // Reset while a held button sits in DELAY; the held button must debounce again.
    btn_right = 1'b1;
    repeat (10) tick();
    do_reset();
    press_hold(4'b0001, 10);
    check("post_rst_x", 32'(x), 32'd129);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
